branch_predictor: RTL

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined CPU.
- Consulted combinationally in IF with the current PC; supplies a predicted next PC, so taken branches and jumps no longer always cost a flush.
- Trained at the clock edge from the EX stage, where branch and jump outcomes are resolved.
- Replaces the fixed "predict not-taken, flush on taken" behaviour of the current pipeline.

---
 rtl/branch_predictor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; IF lookup, EX training.
// Optional statistics counters are enabled with `define BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_all,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
`ifdef BRANCH_PREDICTOR_STATS_EN
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] stat_lookups,
    output logic [STAT_WIDTH-1:0] stat_hits,
    output logic [STAT_WIDTH-1:0] stat_updates,
    output logic [STAT_WIDTH-1:0] stat_mispredicts,
`endif
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict
);

    localparam int IB    = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IB - 2;

    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_ZERO = '0;
    localparam logic [COUNTER_BITS-1:0] CTR_ONE  = 1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = CTR_ONE << (COUNTER_BITS - 1);
    localparam logic [ADDR_WIDTH-1:0]   PC_STEP  = 4;

    logic                    valid_q  [ENTRIES];
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0]   target_q [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

    logic [IB-1:0]    look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IB-1:0]    upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign look_idx = lookup_pc[IB+1:2];
    assign look_tag = lookup_pc[ADDR_WIDTH-1:IB+2];
    assign upd_idx  = upd_pc[IB+1:2];
    assign upd_tag  = upd_pc[ADDR_WIDTH-1:IB+2];

    // Lookup reads stored state only; same-cycle updates are not bypassed.
    always_comb begin
        predict_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        predict_taken  = predict_hit && ctr_q[look_idx][COUNTER_BITS-1];
        predict_target = predict_taken ? target_q[look_idx]
                                       : lookup_pc + PC_STEP;
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_all) begin
            // Program reload: drop entries but keep counters and targets.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_ONE;
                    end
                end else if (ctr_q[upd_idx] != CTR_ZERO) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_ONE;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CTR_WEAK;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [STAT_WIDTH-1:0] lookups_q;
    logic [STAT_WIDTH-1:0] hits_q;
    logic [STAT_WIDTH-1:0] updates_q;
    logic [STAT_WIDTH-1:0] mispredicts_q;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(
        input logic [STAT_WIDTH-1:0] v,
        input logic                  en
    );
        return (en && (v != STAT_MAX)) ? v + STAT_ONE : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            updates_q     <= '0;
            mispredicts_q <= '0;
        end else if (stat_clear) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            updates_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            lookups_q     <= sat_inc(lookups_q, lookup_valid);
            hits_q        <= sat_inc(hits_q, lookup_valid && predict_hit);
            updates_q     <= sat_inc(updates_q, upd_valid);
            mispredicts_q <= sat_inc(mispredicts_q,
                                     upd_valid && upd_mispredict);
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_updates     = updates_q;
    assign stat_mispredicts = mispredicts_q;

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0],
                           lookup_valid, upd_mispredict};
`endif

endmodule
